// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/memory-wait stall and flush, memory timeout, perf counters.
// Stall/flush/forward outputs are combinational; FSM, fault flag and counters update on clk.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_RegWEn,
    input  logic                      ex_MemRead,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      mem_RegWEn,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic                      wb_RegWEn,
    input  logic                      ex_PCSel,
    input  logic                      mem_access,
    input  logic                      dmem_ready,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [1:0]                FwdA,
    output logic [1:0]                FwdB,
    output logic                      mem_fault,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_count
);
    typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, FAULT = 2'd2} state_t;

    state_t                   state_q;
    logic [TIMEOUT_WIDTH-1:0] wait_q;
    logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]     flush_cnt_q, flush_cnt_d;
    logic                     mem_stall, branch_flush, load_use;
    logic                     unused_ex_regwen;

    // A load always writes its destination, so the EX write enable adds nothing here.
    assign unused_ex_regwen = ex_RegWEn;

    always_comb begin
        FwdA = 2'b00;
        if (mem_RegWEn && mem_rd != '0 && mem_rd == ex_rs1)
            FwdA = 2'b10;
        else if (wb_RegWEn && wb_rd != '0 && wb_rd == ex_rs1)
            FwdA = 2'b01;
        FwdB = 2'b00;
        if (mem_RegWEn && mem_rd != '0 && mem_rd == ex_rs2)
            FwdB = 2'b10;
        else if (wb_RegWEn && wb_rd != '0 && wb_rd == ex_rs2)
            FwdB = 2'b01;
    end

    // Memory stall freezes everything and holds EX, so a taken branch survives to the release cycle.
    assign mem_stall    = (mem_access && !dmem_ready) || (state_q == FAULT);
    assign branch_flush = ex_PCSel && !mem_stall;
    assign load_use     = ex_MemRead && (ex_rd != '0)
                          && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
                          && !mem_stall && !ex_PCSel;

    assign StallF    = mem_stall || load_use;
    assign StallD    = mem_stall || load_use;
    assign StallE    = mem_stall;
    assign StallM    = mem_stall;
    assign FlushD    = branch_flush;
    assign FlushE    = branch_flush || load_use;
    assign FlushW    = mem_stall;
    assign mem_fault = (state_q == FAULT);

    assign stall_cnt_d  = (StallF && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    assign flush_cnt_d  = (FlushD && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                RUN: begin
                    wait_q <= '0;
                    if (mem_access && !dmem_ready)
                        state_q <= MWAIT;
                end
                MWAIT: begin
                    if (dmem_ready) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == '1) begin
                        state_q <= FAULT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= RUN;
            endcase
        end
    end
endmodule
